// File: rtl/apb_fifo_bridge.sv
// APB3 slave that bridges a register file to a TX FIFO (APB -> consumer) and an
// RX FIFO (producer -> APB), with sticky error flag and level interrupts.
//
// Ports:
//   PCLK, PRESETn            clock, asynchronous active-low reset
//   PSELx/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR   APB3 slave
//   TX_DATA/TX_VALID/TX_READY  TX FIFO head and handshake towards the consumer
//   RX_DATA/RX_VALID/RX_READY  RX FIFO input handshake from the producer
//   ERROR                    core error flag (sets err_sticky)
//   CONFIG, TIMEOUT          register contents
//   INT_TX/INT_RX/INT_ERR    level interrupts gated by INT_EN
module apb_fifo_bridge #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned TX_DEPTH    = 8,
    parameter int unsigned RX_DEPTH    = 8,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              PSELx,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_VALID,
    input  logic              TX_READY,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic              RX_VALID,
    output logic              RX_READY,
    input  logic              ERROR,
    output logic [13:0]       CONFIG,
    output logic [13:0]       TIMEOUT,
    output logic              INT_TX,
    output logic              INT_RX,
    output logic              INT_ERR
);

    localparam int unsigned TX_PW = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW = TX_PW + 1;
    localparam int unsigned RX_PW = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW = RX_PW + 1;
    localparam int unsigned AW    = ADDR_W - 2;

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            state_q, state_d;
    logic [2:0]        wait_q, wait_d;
    logic [13:0]       config_q, config_d, timeout_q, timeout_d;
    logic [2:0]        int_en_q, int_en_d;
    logic              err_sticky_q, err_sticky_d;

    logic [DATA_W-1:0] tx_mem_q [TX_DEPTH];
    logic [TX_PW-1:0]  tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
    logic [TX_CW-1:0]  tx_cnt_q, tx_cnt_d;
    logic [DATA_W-1:0] rx_mem_q [RX_DEPTH];
    logic [RX_PW-1:0]  rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
    logic [RX_CW-1:0]  rx_cnt_q, rx_cnt_d;

    logic [AW-1:0]     word;
    logic              sel_cfg, sel_tmo, sel_txd, sel_rxd, sel_stat, sel_ien, sel_clr, unmapped;
    logic              pready, acc_err, wr_ok, rd_ok;
    logic              tx_full, tx_empty, rx_full, rx_empty;
    logic              tx_push, tx_pop, rx_push, rx_pop;
    logic [31:0]       status, rdata_full;
    logic              unused_paddr;

    assign word         = PADDR[ADDR_W-1:2];
    assign unused_paddr = ^PADDR[1:0];

    assign tx_full  = (tx_cnt_q == TX_CW'(TX_DEPTH));
    assign tx_empty = (tx_cnt_q == '0);
    assign rx_full  = (rx_cnt_q == RX_CW'(RX_DEPTH));
    assign rx_empty = (rx_cnt_q == '0);

    // Address decode; everything beyond 0x18 is unmapped.
    always_comb begin
        sel_cfg  = 1'b0;
        sel_tmo  = 1'b0;
        sel_txd  = 1'b0;
        sel_rxd  = 1'b0;
        sel_stat = 1'b0;
        sel_ien  = 1'b0;
        sel_clr  = 1'b0;
        unmapped = 1'b0;
        case (word)
            AW'(0):  sel_cfg  = 1'b1;
            AW'(1):  sel_tmo  = 1'b1;
            AW'(2):  sel_txd  = 1'b1;
            AW'(3):  sel_rxd  = 1'b1;
            AW'(4):  sel_stat = 1'b1;
            AW'(5):  sel_ien  = 1'b1;
            AW'(6):  sel_clr  = 1'b1;
            default: unmapped = 1'b1;
        endcase
    end

    // Completion cycle; dropping PSELx cancels it, so no side effect can leak.
    assign pready  = (state_q == StAccess) && (wait_q == 3'd0) && PSELx;
    assign acc_err = unmapped
                   | (PWRITE & (sel_rxd | sel_stat))
                   | (!PWRITE & (sel_txd | sel_clr))
                   | (PWRITE & sel_txd & tx_full)
                   | (!PWRITE & sel_rxd & rx_empty);
    assign wr_ok   = pready & !acc_err & PWRITE;
    assign rd_ok   = pready & !acc_err & !PWRITE;
    assign PREADY  = pready;
    assign PSLVERR = pready & acc_err;

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        unique case (state_q)
            StIdle: begin
                if (PSELx && !PENABLE) state_d = StSetup;
            end
            StSetup: begin
                if (!PSELx) begin
                    state_d = StIdle;
                end else begin
                    state_d = StAccess;
                    wait_d  = 3'(WAIT_STATES);
                end
            end
            StAccess: begin
                if (!PSELx || wait_q == 3'd0) state_d = StIdle;
                else                          wait_d  = wait_q - 3'd1;
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO handshakes. A full TX FIFO errors the write even if a pop happens now.
    assign tx_push = wr_ok & sel_txd;
    assign tx_pop  = !tx_empty & TX_READY;
    assign rx_push = RX_VALID & !rx_full;
    assign rx_pop  = rd_ok & sel_rxd;

    always_comb begin
        config_d     = (wr_ok && sel_cfg) ? PWDATA[13:0] : config_q;
        timeout_d    = (wr_ok && sel_tmo) ? PWDATA[13:0] : timeout_q;
        int_en_d     = (wr_ok && sel_ien) ? PWDATA[2:0]  : int_en_q;
        // Set wins over a simultaneous clear.
        err_sticky_d = ERROR | (err_sticky_q & !(wr_ok & sel_clr & PWDATA[2]));

        tx_wr_d  = tx_push ? tx_wr_q + TX_PW'(1) : tx_wr_q;
        tx_rd_d  = tx_pop  ? tx_rd_q + TX_PW'(1) : tx_rd_q;
        tx_cnt_d = tx_cnt_q;
        if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + TX_CW'(1);
        if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - TX_CW'(1);

        rx_wr_d  = rx_push ? rx_wr_q + RX_PW'(1) : rx_wr_q;
        rx_rd_d  = rx_pop  ? rx_rd_q + RX_PW'(1) : rx_rd_q;
        rx_cnt_d = rx_cnt_q;
        if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + RX_CW'(1);
        if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - RX_CW'(1);
    end

    always_comb begin
        status        = 32'b0;
        status[0]     = tx_full;
        status[1]     = tx_empty;
        status[2]     = rx_full;
        status[3]     = rx_empty;
        status[4]     = err_sticky_q;
        status[11:8]  = 4'(tx_cnt_q);
        status[19:16] = 4'(rx_cnt_q);

        rdata_full = 32'b0;
        if (sel_cfg)  rdata_full[13:0]       = config_q;
        if (sel_tmo)  rdata_full[13:0]       = timeout_q;
        if (sel_rxd)  rdata_full[DATA_W-1:0] = rx_mem_q[rx_rd_q];
        if (sel_stat) rdata_full             = status;
        if (sel_ien)  rdata_full[2:0]        = int_en_q;
        PRDATA = rd_ok ? rdata_full[DATA_W-1:0] : '0;
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q      <= StIdle;
            wait_q       <= 3'd0;
            config_q     <= 14'd0;
            timeout_q    <= 14'd0;
            int_en_q     <= 3'd0;
            err_sticky_q <= 1'b0;
            tx_wr_q      <= '0;
            tx_rd_q      <= '0;
            tx_cnt_q     <= '0;
            rx_wr_q      <= '0;
            rx_rd_q      <= '0;
            rx_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            config_q     <= config_d;
            timeout_q    <= timeout_d;
            int_en_q     <= int_en_d;
            err_sticky_q <= err_sticky_d;
            tx_wr_q      <= tx_wr_d;
            tx_rd_q      <= tx_rd_d;
            tx_cnt_q     <= tx_cnt_d;
            rx_wr_q      <= rx_wr_d;
            rx_rd_q      <= rx_rd_d;
            rx_cnt_q     <= rx_cnt_d;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(TX_DEPTH); i++) tx_mem_q[i] <= '0;
        end else if (tx_push) begin
            tx_mem_q[tx_wr_q] <= PWDATA;
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < int'(RX_DEPTH); i++) rx_mem_q[i] <= '0;
        end else if (rx_push) begin
            rx_mem_q[rx_wr_q] <= RX_DATA;
        end
    end

    assign TX_DATA  = tx_mem_q[tx_rd_q];
    assign TX_VALID = !tx_empty;
    assign RX_READY = !rx_full;
    assign CONFIG   = config_q;
    assign TIMEOUT  = timeout_q;
    assign INT_TX   = int_en_q[0] & tx_empty;
    assign INT_RX   = int_en_q[1] & !rx_empty;
    assign INT_ERR  = int_en_q[2] & err_sticky_q;

endmodule

// File: tb/tb_apb_fifo_bridge.sv
// Self-checking bench for apb_fifo_bridge (WAIT_STATES=2, depth 8 FIFOs).
module tb_apb_fifo_bridge;
    localparam int TXD = 8;
    localparam int RXD = 8;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSELx = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
    logic [7:0]  PADDR = 8'h0;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b0;
    logic [31:0] RX_DATA = 32'h0;
    logic        RX_VALID = 1'b0;
    logic        RX_READY;
    logic        ERROR = 1'b0;
    logic [13:0] CONFIG, TIMEOUT;
    logic        INT_TX, INT_RX, INT_ERR;

    int total = 0;
    int bad = 0;
    logic [31:0] tx_q[$];
    logic [31:0] rx_q[$];

    apb_fifo_bridge #(
        .DATA_W(32), .ADDR_W(8), .TX_DEPTH(TXD), .RX_DEPTH(RXD), .WAIT_STATES(2)
    ) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_READY(TX_READY),
        .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
        .ERROR(ERROR), .CONFIG(CONFIG), .TIMEOUT(TIMEOUT),
        .INT_TX(INT_TX), .INT_RX(INT_RX), .INT_ERR(INT_ERR)
    );

    always #5 PCLK = ~PCLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    // One APB transfer; ncyc = ACCESS cycle on which PREADY rose. Optionally pushes
    // RX data on the completion edge.
    task automatic apb_xfer(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                            input bit rxp, input logic [31:0] rxd,
                            output logic [31:0] rdata, output logic err, output int ncyc);
        rdata = 32'h0;
        err   = 1'b0;
        ncyc  = 0;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        while (1) begin
            @(posedge PCLK); #1;
            ncyc++;
            if (PREADY) break;
            if (ncyc > 40) break;
        end
        if (!PREADY) begin
            total++; bad++;
            $display("FAIL xfer_timeout addr=%h: no PREADY, want PREADY within 40 cycles", addr);
        end
        rdata = PRDATA;
        err   = PSLVERR;
        if (rxp) begin RX_DATA = rxd; RX_VALID = 1'b1; end
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0; RX_VALID = 1'b0;
    endtask

    task automatic rx_produce(input logic [31:0] d);
        RX_DATA = d; RX_VALID = 1'b1;
        if (rx_q.size() < RXD) rx_q.push_back(d);
        @(posedge PCLK); #1;
        RX_VALID = 1'b0;
    endtask

    task automatic test_reset();
        PRESETn = 1'b0;
        repeat (3) @(posedge PCLK);
        #1;
        total++;
        if ({PREADY, PSLVERR, TX_VALID, RX_READY, INT_TX, INT_RX, INT_ERR} !== 7'b0001000) begin
            bad++;
            $display("FAIL reset_ctrl: got %b want 0001000",
                     {PREADY, PSLVERR, TX_VALID, RX_READY, INT_TX, INT_RX, INT_ERR});
        end
        total++;
        if ({PRDATA, CONFIG, TIMEOUT} !== 60'h0) begin
            bad++;
            $display("FAIL reset_regs: got %h/%h/%h want 0", PRDATA, CONFIG, TIMEOUT);
        end
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
    endtask

    task automatic test_config_wait();
        logic [31:0] rd; logic err; int n;
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0000_000A) begin bad++; $display("FAIL status_reset: got %h want 0000000a", rd); end
        apb_xfer(1'b1, 8'h00, 32'h0000_3FFF, 0, 0, rd, err, n);
        total++;
        if (n !== 3 || err !== 1'b0) begin bad++; $display("FAIL cfg_write: got n=%0d err=%b want n=3 err=0", n, err); end
        total++;
        if (CONFIG !== 14'h3FFF) begin bad++; $display("FAIL cfg_port: got %h want 3fff", CONFIG); end
        apb_xfer(1'b0, 8'h00, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h3FFF || n !== 3) begin bad++; $display("FAIL cfg_read: got %h n=%0d want 3fff n=3", rd, n); end
        total++;
        if (PRDATA !== 32'h0 || PREADY !== 1'b0) begin
            bad++; $display("FAIL prdata_idle: got %h rdy=%b want 0 rdy=0", PRDATA, PREADY);
        end
    endtask

    task automatic test_tx_fifo();
        logic [31:0] rd, d, exp; logic err; int n; int pops;
        TX_READY = 1'b0;
        for (int i = 0; i < TXD; i++) begin
            d = 32'hC0DE_0000 + 32'(i) * 32'h101;
            apb_xfer(1'b1, 8'h08, d, 0, 0, rd, err, n);
            tx_q.push_back(d);
            total++;
            if (err !== 1'b0) begin bad++; $display("FAIL tx_push%0d: got err=%b want 0", i, err); end
        end
        apb_xfer(1'b1, 8'h08, 32'hDEAD_BEEF, 0, 0, rd, err, n);
        total++;
        if (err !== 1'b1) begin bad++; $display("FAIL tx_overflow: got err=%b want 1", err); end
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0000_0809) begin bad++; $display("FAIL status_txfull: got %h want 00000809", rd); end
        TX_READY = 1'b1;
        pops = 0;
        for (int c = 0; c < TXD + 4; c++) begin
            if (TX_VALID) begin
                exp = (tx_q.size() > 0) ? tx_q.pop_front() : 32'hFFFF_FFFF;
                total++;
                if (TX_DATA !== exp) begin bad++; $display("FAIL tx_drain%0d: got %h want %h", pops, TX_DATA, exp); end
                pops++;
            end
            @(posedge PCLK); #1;
        end
        TX_READY = 1'b0;
        total++;
        if (pops !== TXD || TX_VALID !== 1'b0) begin
            bad++; $display("FAIL tx_count: got pops=%0d valid=%b want %0d valid=0", pops, TX_VALID, TXD);
        end
    endtask

    task automatic test_rx_fifo();
        logic [31:0] rd, exp; logic err; int n;
        apb_xfer(1'b0, 8'h0C, 0, 0, 0, rd, err, n);
        total++;
        if (err !== 1'b1 || rd !== 32'h0) begin bad++; $display("FAIL rx_empty_read: got err=%b rd=%h want 1/0", err, rd); end
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0000_000A) begin bad++; $display("FAIL rx_level0: got %h want 0000000a", rd); end
        rx_produce(32'h11);
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0001_0002) begin bad++; $display("FAIL rx_level1: got %h want 00010002", rd); end
        exp = rx_q.pop_front();
        apb_xfer(1'b0, 8'h0C, 0, 1, 32'hA5, rd, err, n);
        rx_q.push_back(32'hA5);
        total++;
        if (rd !== exp || err !== 1'b0) begin bad++; $display("FAIL rx_pop_push: got %h err=%b want %h", rd, err, exp); end
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0001_0002) begin bad++; $display("FAIL rx_level_same: got %h want 00010002", rd); end
        exp = rx_q.pop_front();
        apb_xfer(1'b0, 8'h0C, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== exp) begin bad++; $display("FAIL rx_a5: got %h want %h", rd, exp); end
        // Fill to full (pointers wrap), then one extra push must be dropped.
        for (int i = 0; i <= RXD; i++) rx_produce(32'h5000 + 32'(i));
        total++;
        if (RX_READY !== 1'b0) begin bad++; $display("FAIL rx_full_ready: got %b want 0", RX_READY); end
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0008_0006) begin bad++; $display("FAIL rx_full_status: got %h want 00080006", rd); end
        while (rx_q.size() > 0) begin
            exp = rx_q.pop_front();
            apb_xfer(1'b0, 8'h0C, 0, 0, 0, rd, err, n);
            total++;
            if (rd !== exp || err !== 1'b0) begin bad++; $display("FAIL rx_drain: got %h err=%b want %h", rd, err, exp); end
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic err; int n;
        logic [8:0] cases [5];
        cases[0] = {1'b0, 8'h1C}; cases[1] = {1'b0, 8'h08}; cases[2] = {1'b0, 8'h18};
        cases[3] = {1'b1, 8'h10}; cases[4] = {1'b1, 8'h0C};
        for (int i = 0; i < 5; i++) begin
            apb_xfer(cases[i][8], cases[i][7:0], 32'h0, 0, 0, rd, err, n);
            total++;
            if (err !== 1'b1 || rd !== 32'h0) begin
                bad++; $display("FAIL err_case%0d addr=%h: got err=%b rd=%h want 1/0", i, cases[i][7:0], err, rd);
            end
        end
        apb_xfer(1'b1, 8'h20, 32'h0, 0, 0, rd, err, n);
        total++;
        if (err !== 1'b1 || CONFIG !== 14'h3FFF) begin
            bad++; $display("FAIL unmapped_write: got err=%b cfg=%h want 1/3fff", err, CONFIG);
        end
    endtask

    task automatic test_interrupts();
        logic [31:0] rd; logic err; int n;
        apb_xfer(1'b1, 8'h14, 32'h7, 0, 0, rd, err, n);
        apb_xfer(1'b0, 8'h14, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h7) begin bad++; $display("FAIL int_en_read: got %h want 7", rd); end
        total++;
        if ({INT_TX, INT_RX, INT_ERR} !== 3'b100) begin bad++; $display("FAIL int_idle: got %b want 100", {INT_TX, INT_RX, INT_ERR}); end
        ERROR = 1'b1; @(posedge PCLK); #1; ERROR = 1'b0;
        total++;
        if (INT_ERR !== 1'b1) begin bad++; $display("FAIL int_err_set: got %b want 1", INT_ERR); end
        ERROR = 1'b1;
        apb_xfer(1'b1, 8'h18, 32'h4, 0, 0, rd, err, n);
        ERROR = 1'b0;
        @(posedge PCLK); #1;
        total++;
        if (INT_ERR !== 1'b1) begin bad++; $display("FAIL int_err_setwins: got %b want 1", INT_ERR); end
        apb_xfer(1'b1, 8'h18, 32'h4, 0, 0, rd, err, n);
        total++;
        if (INT_ERR !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL int_err_clr: got %b err=%b want 0", INT_ERR, err); end
        rx_produce(32'h5A);
        total++;
        if (INT_RX !== 1'b1) begin bad++; $display("FAIL int_rx: got %b want 1", INT_RX); end
        void'(rx_q.pop_front());
        apb_xfer(1'b0, 8'h0C, 0, 0, 0, rd, err, n);
        total++;
        if (INT_RX !== 1'b0 || rd !== 32'h5A) begin bad++; $display("FAIL int_rx_clr: got %b rd=%h want 0/5a", INT_RX, rd); end
    endtask

    task automatic test_abort();
        logic [31:0] rd; logic err; int n;
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h00; PWDATA = 32'h0123;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSELx = 1'b0; PENABLE = 1'b0;
        repeat (4) @(posedge PCLK);
        #1;
        total++;
        if (CONFIG !== 14'h3FFF) begin bad++; $display("FAIL abort_no_write: got %h want 3fff", CONFIG); end
        apb_xfer(1'b0, 8'h00, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h3FFF || n !== 3) begin bad++; $display("FAIL after_abort: got %h n=%0d want 3fff n=3", rd, n); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic err; int n;
        apb_xfer(1'b1, 8'h08, 32'h77, 0, 0, rd, err, n);
        rx_produce(32'h88);
        apb_xfer(1'b1, 8'h04, 32'h55, 0, 0, rd, err, n);
        total++;
        if (TIMEOUT !== 14'h55) begin bad++; $display("FAIL timeout_write: got %h want 55", TIMEOUT); end
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 8'h04; PWDATA = 32'h1234;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PRESETn = 1'b0;
        #1;
        total++;
        if ({TIMEOUT, CONFIG} !== 28'h0 || {PREADY, PSLVERR, TX_VALID, RX_READY} !== 4'b0001) begin
            bad++;
            $display("FAIL reset_mid: got tmo=%h cfg=%h ctl=%b want 0/0/0001", TIMEOUT, CONFIG,
                     {PREADY, PSLVERR, TX_VALID, RX_READY});
        end
        total++;
        if ({INT_TX, INT_RX, INT_ERR} !== 3'b000) begin bad++; $display("FAIL reset_mid_int: got %b want 000", {INT_TX, INT_RX, INT_ERR}); end
        PSELx = 1'b0; PENABLE = 1'b0;
        tx_q.delete(); rx_q.delete();
        @(posedge PCLK); #1;
        PRESETn = 1'b1;
        @(posedge PCLK); #1;
        apb_xfer(1'b0, 8'h10, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0000_000A) begin bad++; $display("FAIL status_after_reset: got %h want 0000000a", rd); end
        apb_xfer(1'b1, 8'h04, 32'h0ABC, 0, 0, rd, err, n);
        apb_xfer(1'b0, 8'h04, 0, 0, 0, rd, err, n);
        total++;
        if (rd !== 32'h0ABC || TIMEOUT !== 14'h0ABC || n !== 3) begin
            bad++; $display("FAIL first_after_reset: got %h port=%h n=%0d want 0abc n=3", rd, TIMEOUT, n);
        end
    endtask

    initial begin
        test_reset();
        test_config_wait();
        test_tx_fifo();
        test_rx_fifo();
        test_errors();
        test_interrupts();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb_fifo_bridge.md
APB_FIFO_BRIDGE -- requirements
Module: apb_fifo_bridge

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- DATA_W, 32, APB and FIFO data width; allowed range 16..32.
- ADDR_W, 8, PADDR width.
- TX_DEPTH, 8, TX FIFO entries; power of 2, at least 2.
- RX_DEPTH, 8, RX FIFO entries; power of 2, at least 2.
- WAIT_STATES, 0, PREADY-low cycles per access; allowed range 0..7.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- PCLK, in, 1, sole clock; all logic samples on its rising edge.
- PRESETn, in, 1, asynchronous active-low reset.
- PSELx, PENABLE, PWRITE, in, 1 each, APB3 control.
- PADDR, in, ADDR_W, byte address; bits [1:0] ignored.
- PWDATA, in, DATA_W, write data.
- PRDATA, out, DATA_W, read data.
- PREADY, out, 1, transfer complete.
- PSLVERR, out, 1, transfer error.
- TX_DATA, out, DATA_W, TX FIFO head.
- TX_VALID, out, 1, TX FIFO not empty.
- TX_READY, in, 1, consumer accepts TX_DATA.
- RX_DATA, in, DATA_W, producer data.
- RX_VALID, in, 1, producer data valid.
- RX_READY, out, 1, RX FIFO not full.
- ERROR, in, 1, core error flag.
- CONFIG, out, 14, CONFIG register.
- TIMEOUT, out, 14, TIMEOUT register.
- INT_TX, INT_RX, INT_ERR, out, 1 each, interrupt lines.

Function
REQ-003 The register map SHALL be:
- 0x00 CONFIG, RW, bits [13:0].
- 0x04 TIMEOUT, RW, bits [13:0].
- 0x08 TXDATA, WO; a write pushes PWDATA into the TX FIFO.
- 0x0C RXDATA, RO; a read returns and pops the RX FIFO head.
- 0x10 STATUS, RO: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] err_sticky, [11:8] tx_level, [19:16] rx_level.
- 0x14 INT_EN, RW, bits [2:0].
- 0x18 INT_CLR, WO; writing 1 to bit 2 clears err_sticky.
REQ-004 Unused PRDATA bits SHALL read as 0; reads of WO registers SHALL return 0.
REQ-005 The APB FSM SHALL have states IDLE, SETUP and ACCESS.
- IDLE to SETUP when PSELx=1 and PENABLE=0.
- SETUP to ACCESS on the next cycle.
- In ACCESS, a wait counter loaded with WAIT_STATES decrements while PREADY=0; at zero, PREADY=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-006 With WAIT_STATES=0, PREADY SHALL be 1 in the first ACCESS cycle.
REQ-007 Register side effects (write, push, pop, W1C) SHALL occur only on the cycle PREADY=1, once per transfer.
REQ-008 PRDATA SHALL be valid on the cycle PREADY=1 and SHALL be 0 otherwise.
REQ-009 PSLVERR SHALL be asserted only together with PREADY, in any of these cases:
- unmapped address;
- write to 0x0C or 0x10;
- read of 0x08 or 0x18;
- TXDATA write while tx_full;
- RXDATA read while rx_empty.
REQ-010 An errored transfer SHALL have no side effect.
REQ-011 If PSELx deasserts during SETUP or ACCESS, the FSM SHALL return to IDLE with no side effect.
REQ-012 TX_VALID SHALL equal !tx_empty and TX_DATA SHALL equal the TX FIFO head; a pop SHALL occur when TX_VALID and TX_READY are both 1.
REQ-013 A TXDATA write while tx_full SHALL error even if a TX pop occurs in the same cycle.
REQ-014 RX_READY SHALL equal !rx_full; a push SHALL occur when RX_VALID and RX_READY are both 1.
REQ-015 A simultaneous RX push and RXDATA pop SHALL both take effect, leaving rx_level unchanged.
REQ-016 FIFO pointers SHALL wrap modulo depth, and each level SHALL range 0..depth without overflow.
REQ-017 err_sticky SHALL be set on any cycle ERROR=1 and cleared by INT_CLR bit 2; set SHALL win over a simultaneous clear.
REQ-018 Interrupts SHALL be combinational levels:
- INT_TX = INT_EN[0] & tx_empty
- INT_RX = INT_EN[1] & !rx_empty
- INT_ERR = INT_EN[2] & err_sticky

Reset
REQ-019 PRESETn=0 SHALL immediately, without waiting for a clock edge:
- force FSM=IDLE;
- force PREADY, PSLVERR, PRDATA, CONFIG, TIMEOUT, INT_EN and err_sticky to 0;
- empty both FIFOs, so TX_VALID=0, RX_READY=1, INT_TX=INT_RX=INT_ERR=0.
REQ-020 Reset mid-transfer SHALL abort the transfer with no side effect.
REQ-021 The first transfer after reset release SHALL behave normally.

Verification
REQ-022 WAIT_STATES=2; write 0x00=0x3FFF, then read 0x00 -> CONFIG=0x3FFF; PREADY high on the 3rd ACCESS cycle; PRDATA=0x3FFF.
REQ-023 TX_READY=0; write TXDATA TX_DEPTH+1 times -> the last write has PSLVERR=1; tx_full=1; then TX_READY=1 -> data drains in order; TX_VALID falls after TX_DEPTH pops.
REQ-024 RXDATA read while RX empty -> PSLVERR=1 and rx_level stays 0; push 0xA5 while popping from a level of 1 -> rx_level stays 1; the next read returns 0xA5.
REQ-025 INT_EN=7; pulse ERROR -> INT_ERR=1; write INT_CLR=4 while ERROR=1 -> INT_ERR stays 1; write INT_CLR=4 again after ERROR falls -> INT_ERR=0.
REQ-026 Assert PRESETn=0 during ACCESS of a TIMEOUT write -> TIMEOUT=0, PREADY=0, both FIFOs empty.
REQ-027 Read 0x1C -> PSLVERR=1, PRDATA=0.
